// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory stage pipeline slice.
package mem_stage_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RW_DEF   = 5;

  typedef struct packed {
    logic regWrite;
    logic memToReg;
  } wb_ctrl_t;

  typedef struct packed {
    logic memRead;
    logic memWrite;
  } mem_ctrl_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } dmem_state_t;

endpackage

// File: rtl/mem_stage_pipe_pipe_reg.sv
// Width-parameterised pipeline register with load enable and async clear.
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear on reset, otherwise capture when enabled and hold when not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/mem_stage_pipe.sv
// EX/MEM and MEM/WB pipeline registers with data-cache handshake.
// The whole back end is frozen while the cache reports a miss.
// Optional: define MEM_STALL_CNT_EN to build the saturating stall-cycle counter.
module mem_stage_pipe
  import mem_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RW   = RW_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] ex_alu_result_i,
  input  logic [XLEN-1:0] ex_rs2_data_i,
  input  logic [RW-1:0]   ex_rd_i,
  input  logic            ex_reg_write_i,
  input  logic            ex_mem_to_reg_i,
  input  logic            ex_mem_read_i,
  input  logic            ex_mem_write_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_ack_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            stall_o,
  output logic [RW-1:0]   ex_mem_rd_o,
  output logic            ex_mem_reg_write_o,
  output logic [XLEN-1:0] ex_mem_alu_result_o,
  output logic [RW-1:0]   mem_wb_rd_o,
  output logic            mem_wb_reg_write_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic [31:0]     stall_cnt_o
);

  localparam int EXMEM_W = 2 * XLEN + RW + 4;
  localparam int MEMWB_W = 2 * XLEN + RW + 2;

  // EX/MEM fields
  logic [XLEN-1:0] exMemAlu;
  logic [XLEN-1:0] exMemRs2;
  logic [RW-1:0]   exMemRd;
  wb_ctrl_t        exMemWb;
  mem_ctrl_t       exMemMem;

  // MEM/WB fields
  logic [XLEN-1:0] memWbAlu;
  logic [XLEN-1:0] memWbLoad;
  logic [RW-1:0]   memWbRd;
  wb_ctrl_t        memWbWb;

  logic            loadEn;
  logic [XLEN-1:0] loadDataNext;
  wb_ctrl_t        exWb;
  mem_ctrl_t       exMem;
  dmem_state_t     state;

  assign exWb  = '{regWrite: ex_reg_write_i, memToReg: ex_mem_to_reg_i};
  assign exMem = '{memRead: ex_mem_read_i, memWrite: ex_mem_write_i};

  // Handshake is purely a function of the held EX/MEM contents; a store wins if both bits are set.
  assign dmem_req_o   = exMemMem.memRead | exMemMem.memWrite;
  assign dmem_we_o    = exMemMem.memWrite;
  assign dmem_addr_o  = exMemAlu;
  assign dmem_wdata_o = exMemRs2;
  assign stall_o      = dmem_req_o & ~dmem_ack_i;
  assign loadEn       = ~stall_o;

  // Load data is only taken on a real completion; a stray ack keeps the previous value.
  assign loadDataNext = (dmem_req_o & dmem_ack_i) ? dmem_rdata_i : memWbLoad;

  pipe_reg #(.W(EXMEM_W)) uExMem (
    .clk (clk_i),
    .rst (rst_i),
    .en  (loadEn),
    .d   ({ex_alu_result_i, ex_rs2_data_i, ex_rd_i, exWb, exMem}),
    .q   ({exMemAlu, exMemRs2, exMemRd, exMemWb, exMemMem})
  );

  // MEM/WB holds (no bubble) during a stall so its forward stays valid for the frozen EX.
  pipe_reg #(.W(MEMWB_W)) uMemWb (
    .clk (clk_i),
    .rst (rst_i),
    .en  (loadEn),
    .d   ({exMemAlu, loadDataNext, exMemRd, exMemWb}),
    .q   ({memWbAlu, memWbLoad, memWbRd, memWbWb})
  );

  assign ex_mem_rd_o         = exMemRd;
  assign ex_mem_reg_write_o  = exMemWb.regWrite;
  assign ex_mem_alu_result_o = exMemAlu;
  assign mem_wb_rd_o         = memWbRd;
  assign mem_wb_reg_write_o  = memWbWb.regWrite;
  assign wb_data_o           = memWbWb.memToReg ? memWbLoad : memWbAlu;

  // Miss tracker: enters BUSY on an unacknowledged request, leaves on ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (dmem_req_o && !dmem_ack_i) state <= BUSY;
        BUSY:    if (dmem_ack_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_STALL_CNT_EN
  logic [31:0] stallCnt;

  // Count stalled cycles, sticking at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                     stallCnt <= '0;
    else if (stall_o && (stallCnt != 32'hFFFFFFFF)) stallCnt <= stallCnt + 32'd1;
  end

  assign stall_cnt_o = stallCnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed self-checking bench for mem_stage_pipe.
module tb_mem_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] exAlu, exRs2;
  logic [4:0]  exRd;
  logic        exRegWrite, exMemToReg, exMemRead, exMemWrite;
  logic        dmemReq, dmemWe;
  logic [31:0] dmemAddr, dmemWdata;
  logic        dmemAck;
  logic [31:0] dmemRdata;
  logic        stall;
  logic [4:0]  exMemRd;
  logic        exMemRegWrite;
  logic [31:0] exMemAlu;
  logic [4:0]  memWbRd;
  logic        memWbRegWrite;
  logic [31:0] wbData;
  logic [31:0] stallCnt;

  int nChecks = 0;
  int nFails  = 0;

`ifdef MEM_STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_stage_pipe dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .ex_alu_result_i     (exAlu),
    .ex_rs2_data_i       (exRs2),
    .ex_rd_i             (exRd),
    .ex_reg_write_i      (exRegWrite),
    .ex_mem_to_reg_i     (exMemToReg),
    .ex_mem_read_i       (exMemRead),
    .ex_mem_write_i      (exMemWrite),
    .dmem_req_o          (dmemReq),
    .dmem_we_o           (dmemWe),
    .dmem_addr_o         (dmemAddr),
    .dmem_wdata_o        (dmemWdata),
    .dmem_ack_i          (dmemAck),
    .dmem_rdata_i        (dmemRdata),
    .stall_o             (stall),
    .ex_mem_rd_o         (exMemRd),
    .ex_mem_reg_write_o  (exMemRegWrite),
    .ex_mem_alu_result_o (exMemAlu),
    .mem_wb_rd_o         (memWbRd),
    .mem_wb_reg_write_o  (memWbRegWrite),
    .wb_data_o           (wbData),
    .stall_cnt_o         (stallCnt)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic rw, input logic m2r, input logic mr, input logic mw);
    exRd = rd; exAlu = alu; exRs2 = rs2;
    exRegWrite = rw; exMemToReg = m2r; exMemRead = mr; exMemWrite = mw;
  endtask

  task automatic test_reset();
    rst = 1'b1; dmemAck = 1'b0; dmemRdata = '0;
    drive(5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    nChecks++;
    if ({dmemReq, stall, dmemWe, exMemRd, exMemRegWrite, memWbRd, memWbRegWrite} !== '0) begin
      nFails++;
      $display("FAIL reset_ctrl: got req=%b stall=%b we=%b exrd=%0d exrw=%b wbrd=%0d wbrw=%b, expected all 0",
               dmemReq, stall, dmemWe, exMemRd, exMemRegWrite, memWbRd, memWbRegWrite);
    end
    nChecks++;
    if ({dmemAddr, dmemWdata, exMemAlu, wbData, stallCnt} !== '0) begin
      nFails++;
      $display("FAIL reset_data: got addr=%h wdata=%h alu=%h wb=%h cnt=%0d, expected all 0",
               dmemAddr, dmemWdata, exMemAlu, wbData, stallCnt);
    end
    repeat (2) @(posedge clk);
    #4 rst = 1'b0;
    $display("reset: released");
  endtask

  task automatic test_alu_op();
    drive(5'd5, 32'h1234, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    nChecks++;
    if (exMemRd !== 5'd5 || exMemAlu !== 32'h1234 || exMemRegWrite !== 1'b1 || dmemReq !== 1'b0) begin
      nFails++;
      $display("FAIL alu_exmem: got rd=%0d alu=%h rw=%b req=%b, expected rd=5 alu=1234 rw=1 req=0",
               exMemRd, exMemAlu, exMemRegWrite, dmemReq);
    end
    drive(5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    nChecks++;
    if (memWbRd !== 5'd5 || wbData !== 32'h1234 || memWbRegWrite !== 1'b1) begin
      nFails++;
      $display("FAIL alu_memwb: got rd=%0d wb=%h rw=%b, expected rd=5 wb=1234 rw=1",
               memWbRd, wbData, memWbRegWrite);
    end
    $display("alu_op: rd=5 result=1234 written back");
  endtask

  task automatic test_load_hit();
    drive(5'd7, 32'h40, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    dmemAck = 1'b1; dmemRdata = 32'hCAFE;
    #1;
    nChecks++;
    if (dmemReq !== 1'b1 || dmemWe !== 1'b0 || dmemAddr !== 32'h40 || stall !== 1'b0) begin
      nFails++;
      $display("FAIL load_hit_req: got req=%b we=%b addr=%h stall=%b, expected req=1 we=0 addr=40 stall=0",
               dmemReq, dmemWe, dmemAddr, stall);
    end
    tick();
    dmemAck = 1'b0; dmemRdata = '0;
    #1;
    nChecks++;
    if (wbData !== 32'hCAFE || memWbRd !== 5'd7 || dmemReq !== 1'b0 || stall !== 1'b0) begin
      nFails++;
      $display("FAIL load_hit_wb: got wb=%h rd=%0d req=%b stall=%b, expected wb=cafe rd=7 req=0 stall=0",
               wbData, memWbRd, dmemReq, stall);
    end
    $display("load_hit: addr=40 data=cafe");
  endtask

  task automatic test_store_miss();
    drive(5'd9, 32'h99, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd0, 32'h80, 32'hDEAD, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(5'd3, 32'h333, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      nChecks++;
      if (stall !== 1'b1 || dmemReq !== 1'b1 || dmemWe !== 1'b1 || dmemAddr !== 32'h80 ||
          dmemWdata !== 32'hDEAD || memWbRd !== 5'd9 || wbData !== 32'h99) begin
        nFails++;
        $display("FAIL store_miss_hold[%0d]: got stall=%b req=%b we=%b addr=%h wdata=%h wbrd=%0d wb=%h, expected 1 1 1 80 dead 9 99",
                 i, stall, dmemReq, dmemWe, dmemAddr, dmemWdata, memWbRd, wbData);
      end
      tick();
    end
    dmemAck = 1'b1;
    #1;
    nChecks++;
    if (stall !== 1'b0 || memWbRd !== 5'd9 || wbData !== 32'h99) begin
      nFails++;
      $display("FAIL store_ack_cycle: got stall=%b wbrd=%0d wb=%h, expected stall=0 wbrd=9 wb=99",
               stall, memWbRd, wbData);
    end
    tick();
    dmemAck = 1'b0;
    #1;
    nChecks++;
    if (memWbRd !== 5'd0 || memWbRegWrite !== 1'b0 || wbData !== 32'h80 ||
        exMemRd !== 5'd3 || exMemAlu !== 32'h333 || dmemReq !== 1'b0) begin
      nFails++;
      $display("FAIL store_after_ack: got wbrd=%0d wbrw=%b wb=%h exrd=%0d exalu=%h req=%b, expected 0 0 80 3 333 0",
               memWbRd, memWbRegWrite, wbData, exMemRd, exMemAlu, dmemReq);
    end
    nChecks++;
    if (stallCnt !== (CNT_ON ? 32'd3 : 32'd0)) begin
      nFails++;
      $display("FAIL store_stall_cnt: got %0d expected %0d", stallCnt, CNT_ON ? 3 : 0);
    end
    $display("store_miss: 3 stall cycles, addr=80 wdata=dead");
  endtask

  task automatic test_load_miss_toggle();
    drive(5'd11, 32'h100, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(5'(12 + i), 32'h500 + 32'(i), 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      nChecks++;
      if (stall !== 1'b1 || exMemRd !== 5'd11 || dmemAddr !== 32'h100 || memWbRd !== 5'd3) begin
        nFails++;
        $display("FAIL load_miss_hold[%0d]: got stall=%b exrd=%0d addr=%h wbrd=%0d, expected 1 11 100 3",
                 i, stall, exMemRd, dmemAddr, memWbRd);
      end
      tick();
    end
    drive(5'd20, 32'h777, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    dmemAck = 1'b1; dmemRdata = 32'hBEEF;
    tick();
    dmemAck = 1'b0; dmemRdata = '0;
    #1;
    nChecks++;
    if (exMemRd !== 5'd20 || exMemAlu !== 32'h777 || memWbRd !== 5'd11 || wbData !== 32'hBEEF) begin
      nFails++;
      $display("FAIL load_miss_after_ack: got exrd=%0d exalu=%h wbrd=%0d wb=%h, expected 20 777 11 beef",
               exMemRd, exMemAlu, memWbRd, wbData);
    end
    nChecks++;
    if (stallCnt !== (CNT_ON ? 32'd5 : 32'd0)) begin
      nFails++;
      $display("FAIL load_stall_cnt: got %0d expected %0d", stallCnt, CNT_ON ? 5 : 0);
    end
    $display("load_miss: held addr=100 through toggling inputs, data=beef");
  endtask

  task automatic test_reset_busy();
    drive(5'd4, 32'h200, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    nChecks++;
    if (stall !== 1'b1 || dmemReq !== 1'b1) begin
      nFails++;
      $display("FAIL busy_before_reset: got stall=%b req=%b, expected 1 1", stall, dmemReq);
    end
    rst = 1'b1;
    #1;
    nChecks++;
    if (stall !== 1'b0 || dmemReq !== 1'b0 || exMemRd !== 5'd0 || memWbRd !== 5'd0 ||
        wbData !== 32'h0 || stallCnt !== 32'h0) begin
      nFails++;
      $display("FAIL async_reset: got stall=%b req=%b exrd=%0d wbrd=%0d wb=%h cnt=%0d, expected all 0",
               stall, dmemReq, exMemRd, memWbRd, wbData, stallCnt);
    end
    #2 rst = 1'b0;
    tick();
    nChecks++;
    if ({stall, dmemReq, exMemRd, exMemAlu, memWbRd, wbData, stallCnt} !== '0) begin
      nFails++;
      $display("FAIL after_reset_release: got stall=%b req=%b exrd=%0d exalu=%h wbrd=%0d wb=%h cnt=%0d, expected all 0",
               stall, dmemReq, exMemRd, exMemAlu, memWbRd, wbData, stallCnt);
    end
    $display("reset_busy: request dropped asynchronously");
  endtask

  task automatic test_spurious_ack();
    drive(5'd6, 32'h66, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    dmemAck = 1'b1; dmemRdata = 32'hFFFF;
    #1;
    nChecks++;
    if (stall !== 1'b0 || dmemReq !== 1'b0) begin
      nFails++;
      $display("FAIL spurious_ack_comb: got stall=%b req=%b, expected 0 0", stall, dmemReq);
    end
    tick();
    dmemAck = 1'b0; dmemRdata = '0;
    #1;
    nChecks++;
    if (exMemRd !== 5'd6 || memWbRd !== 5'd6 || wbData !== 32'h66 || stallCnt !== 32'd0) begin
      nFails++;
      $display("FAIL spurious_ack_regs: got exrd=%0d wbrd=%0d wb=%h cnt=%0d, expected 6 6 66 0",
               exMemRd, memWbRd, wbData, stallCnt);
    end
    // A later mem_to_reg instruction without a real load must not see the stray ack data.
    drive(5'd8, 32'h88, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    nChecks++;
    if (wbData !== 32'h0) begin
      nFails++;
      $display("FAIL spurious_ack_data: got wb=%h expected 0", wbData);
    end
    $display("spurious_ack: ignored");
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_alu_op();
        test_load_hit();
        test_store_miss();
        test_load_miss_toggle();
        test_reset_busy();
        test_spurious_ack();
      end
      begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
